// File: rtl/seven_seg_scan_display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment driver.
// Contents:
//   SEG_* active-low cathode patterns (bit7 = dp, bits6:0 = g..a).
//   conv_state_t, the state of the sequential binary-to-BCD engine.
//   clog2, pow10 and seg_decode helper functions.
package seven_seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        CV_IDLE,
        CV_SHIFT,
        CV_COMMIT
    } conv_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_scan_display_if.sv
// Bus between the display driver and its user.
// Signals:
//   value, load, dp_mask, enable  user -> driver
//   busy, segment, an_val         driver -> user (segment/an_val active low)
interface seven_seg_scan_display_if #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14
);
    logic [VALUE_W-1:0]    value;
    logic                  load;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic                  enable;
    logic                  busy;
    logic [7:0]            segment;
    logic [NUM_DIGITS-1:0] an_val;

    modport master (output value, load, dp_mask, enable,
                    input  busy, segment, an_val);
    modport slave  (input  value, load, dp_mask, enable,
                    output busy, segment, an_val);
endinterface

// File: rtl/seven_seg_scan_display_bin2bcd_seq.sv
// Iterative double-dabble converter: one shift-add-3 step per cycle for
// VALUE_W cycles, then one COMMIT cycle in which done is high and bcd holds
// the result. Only the low NUM_DIGITS BCD digits are kept; the upper digits
// never feed back into the lower ones, so those stay exact for any input.
// Ports:
//   clock, reset  synchronous active-high reset
//   start, value  start a conversion of value (ignored while busy)
//   busy          conversion in progress (SHIFT or COMMIT)
//   done          high for the commit cycle
//   bcd           packed BCD digits, digit 0 in bits 3:0
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
)(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      value,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_DIGITS*4-1:0] bcd
);
    localparam int CNT_W = clog2(VALUE_W + 1);

    conv_state_t             state, state_nxt;
    logic [VALUE_W-1:0]      sr;
    logic [NUM_DIGITS*4-1:0] acc, adj;
    logic [CNT_W-1:0]        cnt;

    always_ff @(posedge clock) begin
        if (reset) state <= CV_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CV_IDLE:   if (start) state_nxt = CV_SHIFT;
            CV_SHIFT:  if (cnt == CNT_W'(VALUE_W - 1)) state_nxt = CV_COMMIT;
            CV_COMMIT: state_nxt = CV_IDLE;
            default:   state_nxt = CV_IDLE;
        endcase
    end

    // add 3 to every digit >= 5 before the shift
    always_comb begin
        adj = acc;
        for (int d = 0; d < NUM_DIGITS; d++)
            if (acc[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sr  <= '0;
            acc <= '0;
            cnt <= '0;
        end else begin
            case (state)
                CV_IDLE: if (start) begin
                    sr  <= value;
                    acc <= '0;
                    cnt <= '0;
                end
                CV_SHIFT: begin
                    acc <= {adj[NUM_DIGITS*4-2:0], sr[VALUE_W-1]};
                    sr  <= sr << 1;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != CV_IDLE);
    assign done = (state == CV_COMMIT);
    assign bcd  = acc;

endmodule

// File: rtl/seven_seg_scan_display.sv
// Multiplexed NUM_DIGITS 7-segment driver. A load strobe starts a sequential
// BCD conversion; the result and overflow flag land in the display registers
// together on the commit edge, so the scan never shows a half-updated value.
// A load during a conversion parks in a single pending slot (last wins) and
// starts once the engine returns to idle.
// Ports:
//   clock, reset  synchronous active-high reset
//   disp          slave side of seven_seg_scan_display_if
module seven_seg_scan_display
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int VALUE_W       = 14,
    parameter int REFRESH_DIV   = 25000,
    parameter int BLANK_LEADING = 1
)(
    input  logic                    clock,
    input  logic                    reset,
    seven_seg_scan_display_if.slave disp
);
    localparam int          IDX_W   = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam int          DIV_W   = clog2(REFRESH_DIV);
    localparam logic [31:0] OVF_LIM = pow10(NUM_DIGITS);

    logic                         conv_busy, conv_done, start;
    logic [NUM_DIGITS*4-1:0]      conv_bcd;
    logic [VALUE_W-1:0]           start_val, pend_val;
    logic                         pend_vld, ovf_cap, ovf;
    logic [NUM_DIGITS-1:0][3:0]   digits;
    logic [NUM_DIGITS:0]          upper_zero;
    logic [DIV_W-1:0]             div_cnt;
    logic [IDX_W-1:0]             idx;
    logic [7:0]                   seg_nxt, seg_q;
    logic [NUM_DIGITS-1:0]        an_nxt, an_q;

    // a fresh load takes precedence over an older pending value
    assign start     = !conv_busy && (disp.load || pend_vld);
    assign start_val = disp.load ? disp.value : pend_val;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clock (clock),
        .reset (reset),
        .start (start),
        .value (start_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // load while busy (including the commit cycle) goes to the pending slot
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_vld <= 1'b0;
            pend_val <= '0;
            ovf_cap  <= 1'b0;
            ovf      <= 1'b0;
            digits   <= '0;
        end else begin
            if (start) begin
                pend_vld <= 1'b0;
                ovf_cap  <= ({{(32-VALUE_W){1'b0}}, start_val} >= OVF_LIM);
            end else if (disp.load) begin
                pend_vld <= 1'b1;
                pend_val <= disp.value;
            end
            if (conv_done) begin
                digits <= conv_bcd;
                ovf    <= ovf_cap;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // upper_zero[i]: digits i..NUM_DIGITS-1 are all zero
    always_comb begin
        upper_zero             = '0;
        upper_zero[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            upper_zero[i] = upper_zero[i+1] && (digits[i] == 4'd0);
    end

    always_comb begin
        seg_nxt = SEG_BLANK;
        an_nxt  = '1;
        if (disp.enable) begin
            if (ovf)
                seg_nxt = SEG_DASH;
            else if (BLANK_LEADING != 0 && idx != '0 && upper_zero[idx])
                seg_nxt = SEG_BLANK;
            else
                seg_nxt = seg_decode(digits[idx]);
            if (disp.dp_mask[idx]) seg_nxt[7] = 1'b0;
            an_nxt[idx] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            seg_q <= seg_nxt;
            an_q  <= an_nxt;
        end
    end

    assign disp.segment = seg_q;
    assign disp.an_val  = an_q;
    assign disp.busy    = conv_busy;

endmodule

// File: tb/tb_seven_seg_scan_display.sv
module tb_seven_seg_scan_display;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errs   = 0;
    int   checks = 0;
    logic [7:0] fr [4];

    seven_seg_scan_display_if #(.NUM_DIGITS(4), .VALUE_W(14)) disp_if ();

    seven_seg_scan_display #(
        .NUM_DIGITS    (4),
        .VALUE_W       (14),
        .REFRESH_DIV   (4),
        .BLANK_LEADING (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .disp  (disp_if)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input int v);
        disp_if.value = 14'(v);
        disp_if.load  = 1'b1;
        step();
        disp_if.load  = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (disp_if.busy && n < bound) begin
            step();
            n++;
        end
        chk("idle_timeout", {31'd0, disp_if.busy}, 32'd0);
    endtask

    // 16 cycles covers every digit for REFRESH_DIV=4, NUM_DIGITS=4
    task automatic cap_frame();
        logic [3:0] m;
        for (int d = 0; d < 4; d++) fr[d] = 8'h00;
        repeat (16) begin
            step();
            for (int d = 0; d < 4; d++) begin
                m = 4'b0001 << d;
                if (disp_if.an_val == ~m) fr[d] = disp_if.segment;
            end
        end
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
        cap_frame();
        chk({tag, "_d0"}, {24'd0, fr[0]}, {24'd0, e0});
        chk({tag, "_d1"}, {24'd0, fr[1]}, {24'd0, e1});
        chk({tag, "_d2"}, {24'd0, fr[2]}, {24'd0, e2});
        chk({tag, "_d3"}, {24'd0, fr[3]}, {24'd0, e3});
    endtask

    initial begin
        int         n;
        logic [3:0] ea;
        logic       late;
        disp_if.value   = '0;
        disp_if.load    = 1'b0;
        disp_if.dp_mask = '0;
        disp_if.enable  = 1'b1;

        // reset state
        step();
        step();
        chk("rst_seg",  {24'd0, disp_if.segment}, 32'hFF);
        chk("rst_an",   {28'd0, disp_if.an_val},  32'hF);
        chk("rst_busy", {31'd0, disp_if.busy},    32'd0);
        reset = 1'b0;

        // 1: idle scan, 4-cycle dwell per anode, only digit 0 lit with "0"
        for (int k = 1; k <= 16; k++) begin
            step();
            ea = ~(4'b0001 << ((k - 1) / 4));
            chk("scan_an",  {28'd0, disp_if.an_val},  {28'd0, ea});
            chk("scan_seg", {24'd0, disp_if.segment}, (k <= 4) ? 32'hC0 : 32'hFF);
            chk("scan_busy", {31'd0, disp_if.busy}, 32'd0);
        end

        // 2: 1234, busy for VALUE_W+1 cycles
        do_load(1234);
        n = 0;
        while (disp_if.busy && n < 100) begin
            step();
            n++;
        end
        chk("busy_len", n, 32'd15);
        chk_frame("v1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);

        // 3: top of range and overflow
        do_load(9999);   wait_idle(40);
        chk_frame("v9999", 8'h90, 8'h90, 8'h90, 8'h90);
        do_load(10000);  wait_idle(40);
        chk_frame("v10000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        disp_if.dp_mask = 4'b0001;
        do_load(16383);  wait_idle(40);
        chk_frame("v16383dp", 8'hBF, 8'hBF, 8'hBF, 8'h3F);
        disp_if.dp_mask = 4'b0000;

        // 4a: 7 then 42 two cycles later; 7 holds until 42 commits
        do_load(7);
        step();
        do_load(42);
        wait_idle(40);
        chk_frame("v7", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
        chk("pend_commit", {31'd0, disp_if.busy}, 32'd0);
        chk_frame("v42", 8'hFF, 8'hFF, 8'h99, 8'hA4);

        // 4b: third load replaces the pending value
        do_load(7);
        step();
        do_load(42);
        step();
        step();
        do_load(58);
        repeat (40) step();
        chk("pend_idle", {31'd0, disp_if.busy}, 32'd0);
        chk_frame("v58", 8'hFF, 8'hFF, 8'h92, 8'h80);

        // 4c: load on the commit edge is queued
        do_load(3);
        repeat (14) step();
        do_load(9);
        chk("commit_busy", {31'd0, disp_if.busy}, 32'd0);
        step();
        chk("queued_busy", {31'd0, disp_if.busy}, 32'd1);
        wait_idle(40);
        chk_frame("v9", 8'hFF, 8'hFF, 8'hFF, 8'h90);

        // 5: dp on a blanked digit, then enable=0
        disp_if.dp_mask = 4'b0100;
        do_load(5);  wait_idle(40);
        chk_frame("v5dp", 8'hFF, 8'h7F, 8'hFF, 8'h92);
        disp_if.enable = 1'b0;
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            chk("dis_seg", {24'd0, disp_if.segment}, 32'hFF);
            chk("dis_an",  {28'd0, disp_if.an_val},  32'hF);
        end
        disp_if.enable  = 1'b1;
        disp_if.dp_mask = 4'b0000;

        // 6: reset mid-conversion with a pending load
        do_load(1234);
        repeat (3) step();
        do_load(77);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, disp_if.busy},    32'd0);
        chk("mid_rst_seg",  {24'd0, disp_if.segment}, 32'hFF);
        chk("mid_rst_an",   {28'd0, disp_if.an_val},  32'hF);
        late = 1'b0;
        repeat (40) begin
            step();
            if (disp_if.busy) late = 1'b1;
        end
        chk("no_late_busy", {31'd0, late}, 32'd0);
        chk_frame("v0", 8'hFF, 8'hFF, 8'hFF, 8'hC0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
